// File: rtl/funit_seq_if.sv
// Handshake and operand/result bundle for funit_seq.
//   master: drives opa, opb, fs, rw, start; observes busy, done, fout, fout_hi, psw
//   slave : the function unit side (directions reversed)
interface funit_seq_if #(
  parameter int unsigned bw = 8
) ();
  logic [bw-1:0] opa;
  logic [bw-1:0] opb;
  logic [3:0]    fs;
  logic          rw;
  logic          start;
  logic          busy;
  logic          done;
  logic [bw-1:0] fout;
  logic [bw-1:0] fout_hi;
  logic [3:0]    psw;

  modport master (
    output opa, opb, fs, rw, start,
    input  busy, done, fout, fout_hi, psw
  );

  modport slave (
    input  opa, opb, fs, rw, start,
    output busy, done, fout, fout_hi, psw
  );
endinterface

// File: rtl/funit_seq.sv
// Multi-cycle function unit: single-cycle ALU/shift ops plus iterative unsigned
// multiply (shift-add) and divide (restoring), with a registered {Z,N,C,V} PSW.
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : funit_seq_if slave (opa/opb/fs/rw/start in; busy/done/fout/fout_hi/psw out)
module funit_seq #(
  parameter int unsigned bw = 8
) (
  input logic        clk,
  input logic        rst,
  funit_seq_if.slave bus
);

  localparam int unsigned CntW = $clog2(bw + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [bw-1:0]   hi_q, hi_d;      // MUL product high / DIV partial remainder
  logic [bw-1:0]   lo_q, lo_d;      // MUL multiplier->product low / DIV dividend->quotient
  logic [bw-1:0]   dvs_q, dvs_d;    // latched opb: multiplicand or divisor
  logic            div_q, div_d;
  logic            rw_q, rw_d;
  logic [bw-1:0]   fout_q, fout_d;
  logic [bw-1:0]   fout_hi_q, fout_hi_d;
  logic [3:0]      psw_q, psw_d;

  // Single-cycle result path, straight from the bus operands.
  logic [bw-1:0] alu_res;
  logic          alu_c, alu_v;
  logic [bw:0]   add_w, sub_w;

  always_comb begin
    add_w   = {1'b0, bus.opa} + {1'b0, bus.opb};
    sub_w   = {1'b0, bus.opa} - {1'b0, bus.opb};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (bus.fs)
      4'd0: begin
        alu_res = add_w[bw-1:0];
        alu_c   = add_w[bw];
        alu_v   = (bus.opa[bw-1] == bus.opb[bw-1]) && (add_w[bw-1] != bus.opa[bw-1]);
      end
      4'd1: begin
        alu_res = sub_w[bw-1:0];
        alu_c   = sub_w[bw];  // wrap-around of the extended difference is the borrow
        alu_v   = (bus.opa[bw-1] != bus.opb[bw-1]) && (sub_w[bw-1] != bus.opa[bw-1]);
      end
      4'd2:  alu_res = bus.opa & bus.opb;
      4'd3:  alu_res = bus.opa | bus.opb;
      4'd4:  alu_res = bus.opa ^ bus.opb;
      4'd5:  alu_res = ~bus.opa;
      4'd6:  alu_res = bus.opb;
      4'd7: begin
        alu_res = {bus.opa[bw-2:0], 1'b0};
        alu_c   = bus.opa[bw-1];
      end
      4'd8: begin
        alu_res = {1'b0, bus.opa[bw-1:1]};
        alu_c   = bus.opa[0];
      end
      4'd9: begin
        alu_res = {bus.opa[bw-1], bus.opa[bw-1:1]};
        alu_c   = bus.opa[0];
      end
      4'd10: begin
        alu_res = {bus.opa[bw-2:0], bus.opa[bw-1]};
        alu_c   = bus.opa[bw-1];
      end
      4'd11: begin
        alu_res = {bus.opa[0], bus.opa[bw-1:1]};
        alu_c   = bus.opa[0];
      end
      default: ;  // MUL/DIV handled elsewhere; reserved codes give 0
    endcase
  end

  // One iteration of the shift-add multiplier and the restoring divider.
  logic [bw:0]   mul_sum;
  logic [bw-1:0] mul_hi, mul_lo;
  logic [bw:0]   div_sh, div_diff;
  logic          div_ge;
  logic [bw-1:0] div_rem, div_quo;
  logic [bw-1:0] it_hi, it_lo;

  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dvs_q} : {(bw + 1){1'b0}});
    mul_hi   = mul_sum[bw:1];
    mul_lo   = {mul_sum[0], lo_q[bw-1:1]};
    div_sh   = {hi_q, lo_q[bw-1]};
    div_diff = div_sh - {1'b0, dvs_q};
    div_ge   = (div_sh >= {1'b0, dvs_q});
    // Remainder stays below the divisor, so the low bw bits are exact.
    div_rem  = div_ge ? div_diff[bw-1:0] : div_sh[bw-1:0];
    div_quo  = {lo_q[bw-2:0], div_ge};
    it_hi    = div_q ? div_rem : mul_hi;
    it_lo    = div_q ? div_quo : mul_lo;
  end

  // FSM next state and completion write-back.
  logic          cmp_en, cmp_rw, cmp_c, cmp_v;
  logic [bw-1:0] cmp_res, cmp_hi;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dvs_d     = dvs_q;
    div_d     = div_q;
    rw_d      = rw_q;
    fout_d    = fout_q;
    fout_hi_d = fout_hi_q;
    psw_d     = psw_q;
    cmp_en    = 1'b0;
    cmp_rw    = 1'b0;
    cmp_c     = 1'b0;
    cmp_v     = 1'b0;
    cmp_res   = '0;
    cmp_hi    = '0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (bus.fs == 4'd12 || (bus.fs == 4'd13 && bus.opb != '0)) begin
            hi_d    = '0;
            lo_d    = bus.opa;
            dvs_d   = bus.opb;
            div_d   = (bus.fs == 4'd13);
            rw_d    = bus.rw;
            cnt_d   = CntW'(bw);
            state_d = StRun;
          end else begin
            cmp_en  = 1'b1;
            cmp_rw  = bus.rw;
            state_d = StDone;
            if (bus.fs == 4'd13) begin
              cmp_res = '1;
              cmp_hi  = bus.opa;
              cmp_v   = 1'b1;
            end else begin
              cmp_res = alu_res;
              cmp_c   = alu_c;
              cmp_v   = alu_v;
            end
          end
        end
      end
      StRun: begin
        hi_d  = it_hi;
        lo_d  = it_lo;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CntW'(1)) begin
          cmp_en  = 1'b1;
          cmp_rw  = rw_q;
          cmp_res = it_lo;
          cmp_hi  = it_hi;
          cmp_c   = ~div_q & (|mul_hi);
          cmp_v   = ~div_q & (|mul_hi);
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (cmp_en) begin
      fout_d    = cmp_res;
      fout_hi_d = cmp_hi;
      if (cmp_rw) psw_d = {~|cmp_res, cmp_res[bw-1], cmp_c, cmp_v};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      dvs_q     <= '0;
      div_q     <= 1'b0;
      rw_q      <= 1'b0;
      fout_q    <= '0;
      fout_hi_q <= '0;
      psw_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      dvs_q     <= dvs_d;
      div_q     <= div_d;
      rw_q      <= rw_d;
      fout_q    <= fout_d;
      fout_hi_q <= fout_hi_d;
      psw_q     <= psw_d;
    end
  end

  assign bus.busy    = (state_q == StRun);
  assign bus.done    = (state_q == StDone);
  assign bus.fout    = fout_q;
  assign bus.fout_hi = fout_hi_q;
  assign bus.psw     = psw_q;

endmodule

// File: tb/tb_funit_seq.sv
// Scoreboard bench for funit_seq (bw=8): expected results are pushed when an op
// is driven and popped when done is observed.
module tb_funit_seq;

  localparam int unsigned BW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  funit_seq_if #(.bw(BW)) bus ();

  funit_seq #(.bw(BW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [BW-1:0] fout;
    logic [BW-1:0] hi;
    logic [3:0]    psw;
  } exp_t;

  exp_t     sb[$];
  logic [3:0] psw_m;
  int       n_checks = 0;
  int       n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model written with plain integer arithmetic.
  function automatic exp_t model(input logic [3:0] fs, input logic [7:0] a, input logic [7:0] b,
                                 input logic rw, input logic [3:0] prev);
    exp_t e;
    int ia, ib, sa, sb_, r, h, s;
    logic c, v;
    ia = int'(a);
    ib = int'(b);
    sa = (ia >= 128) ? ia - 256 : ia;
    sb_ = (ib >= 128) ? ib - 256 : ib;
    r = 0; h = 0; c = 1'b0; v = 1'b0;
    case (fs)
      4'd0: begin r = ia + ib; c = (r > 255); s = sa + sb_; v = (s > 127 || s < -128); end
      4'd1: begin r = ia - ib; c = (ia < ib); s = sa - sb_; v = (s > 127 || s < -128); end
      4'd2: r = ia & ib;
      4'd3: r = ia | ib;
      4'd4: r = ia ^ ib;
      4'd5: r = 255 - ia;
      4'd6: r = ib;
      4'd7: begin r = ia * 2; c = (ia >= 128); end
      4'd8: begin r = ia / 2; c = (ia % 2 == 1); end
      4'd9: begin r = ia / 2 + ((ia >= 128) ? 128 : 0); c = (ia % 2 == 1); end
      4'd10: begin r = ia * 2 + ia / 128; c = (ia >= 128); end
      4'd11: begin r = ia / 2 + (ia % 2) * 128; c = (ia % 2 == 1); end
      4'd12: begin r = ia * ib; h = r / 256; c = (h != 0); v = c; end
      4'd13: begin
        if (ib == 0) begin r = 255; h = ia; v = 1'b1; end
        else begin r = ia / ib; h = ia % ib; end
      end
      default: r = 0;
    endcase
    r = r & 255;
    e.fout = 8'(r);
    e.hi   = 8'(h);
    e.psw  = rw ? {(r == 0), (r >= 128), c, v} : prev;
    return e;
  endfunction

  // Issues one op and waits (bounded) for its done; optionally pokes start mid-run.
  task automatic run_op(input logic [3:0] fs, input logic [7:0] a, input logic [7:0] b,
                        input logic rw, input bit poke);
    exp_t e;
    int   n, nb;
    bit   got, iter;
    @(negedge clk);
    bus.fs = fs; bus.opa = a; bus.opb = b; bus.rw = rw; bus.start = 1'b1;
    e = model(fs, a, b, rw, psw_m);
    psw_m = e.psw;
    sb.push_back(e);
    iter = (fs == 4'd12) || (fs == 4'd13 && b != 8'd0);
    n = 0; nb = 0; got = 1'b0;
    while (!got && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (bus.done) got = 1'b1;
      else if (bus.busy) nb++;
      if (!got) begin
        @(negedge clk);
        bus.start = poke && (n == 3);
        if (n == 1) begin
          bus.opa = 8'($urandom); bus.opb = 8'($urandom);
          bus.fs = 4'($urandom); bus.rw = 1'($urandom);
        end
      end
    end
    check("done_latency", n, iter ? BW + 1 : 1);
    check("busy_cycles", nb, iter ? BW : 0);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Monitor: pop on every done pulse.
  initial begin
    exp_t e;
    logic prev_done;
    prev_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (bus.done) begin
        if (prev_done) check("done_width", 2, 1);
        if (sb.size() == 0) check("spurious_done", 1, 0);
        else begin
          e = sb.pop_front();
          check("fout", bus.fout, e.fout);
          check("fout_hi", bus.fout_hi, e.hi);
          check("psw", bus.psw, e.psw);
        end
      end
      prev_done = bus.done;
    end
  end

  initial begin
    int nb;
    rst = 1'b1;
    bus.start = 1'b0; bus.opa = '0; bus.opb = '0; bus.fs = '0; bus.rw = 1'b0;
    psw_m = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_fout", bus.fout, 0);
    check("rst_fout_hi", bus.fout_hi, 0);
    check("rst_psw", bus.psw, 0);
    @(negedge clk);
    rst = 1'b0;

    run_op(4'd0, 8'h7F, 8'h01, 1'b1, 1'b0);   // ADD overflow
    run_op(4'd1, 8'h00, 8'h01, 1'b0, 1'b0);   // SUB, psw held
    run_op(4'd12, 8'hFF, 8'hFF, 1'b1, 1'b1);  // MUL with mid-run start
    run_op(4'd13, 8'd200, 8'd7, 1'b1, 1'b0);  // DIV
    run_op(4'd13, 8'd5, 8'd0, 1'b1, 1'b0);    // DIV by zero
    run_op(4'd11, 8'h01, 8'h00, 1'b1, 1'b0);  // ROR
    run_op(4'd7, 8'h80, 8'h00, 1'b1, 1'b0);   // SHL

    // Reset during RUN cycle 4 of a MUL: no completion, state cleared.
    @(negedge clk);
    bus.fs = 4'd12; bus.opa = 8'hFF; bus.opb = 8'hFF; bus.rw = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_fout", bus.fout, 0);
    check("abort_psw", bus.psw, 0);
    psw_m = 4'h0;
    @(negedge clk);
    rst = 1'b0;
    nb = 0;
    repeat (BW + 3) begin
      @(posedge clk); #1;
      if (bus.busy) nb++;
    end
    check("abort_quiet_busy", nb, 0);
    run_op(4'd12, 8'd13, 8'd11, 1'b1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      if (i % 7 == 0) b = 8'd0;
      run_op(4'($urandom_range(0, 15)), 8'($urandom), b, 1'($urandom), 1'(i % 5 == 0));
    end

    repeat (3) @(posedge clk);
    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
